dmem_arbiter: RTL and testbench

- Two-master arbiter for the single-port synchronous data memory of the single-cycle computer.
- Port 0 is the CPU data port (lw/sw); port 1 is a debug/loader port that preloads or inspects data memory while the CPU runs.
- Serialises accesses, drives the memory for one cycle, and returns a one-cycle ack with read data.
- Rejects misaligned word accesses without touching memory.

---
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory.
// Each grant runs IDLE -> ISSUE -> DONE, giving one memory cycle and a one-cycle ack.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state_reg, state_next;
  logic          gnt_reg, gnt_next;
  logic          last_reg, last_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          err_flag_reg, err_flag_next;
  logic [1:0]    ack_reg, ack_next;
  logic [1:0]    err_out_reg, err_out_next;
  logic          mem_en_reg, mem_en_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;

  logic [1:0]    req_v, we_v;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v [2];
  logic [DW-1:0] rdata_v [2];
  logic [DW-1:0] rdata_hold_reg [2];
  logic [1:0]    rd_live;
  logic          sel;
  logic          mis;

  assign req_v      = {req1, req0};
  assign we_v       = {we1, we0};
  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    last_next      = last_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    err_flag_next  = err_flag_reg;
    ack_next       = 2'b00;
    err_out_next   = 2'b00;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    sel            = 1'b0;
    mis            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_v != 2'b00) begin
          if (req_v == 2'b11)
            sel = (FIXED_PRI != 0) ? 1'b0 : ~last_reg;
          else
            sel = req_v[1];
          // Alignment is decided at grant so the ISSUE-cycle strobes can be registered.
          mis           = (addr_v[sel][1:0] != 2'b00);
          gnt_next      = sel;
          we_next       = we_v[sel];
          addr_next     = addr_v[sel];
          wdata_next    = wdata_v[sel];
          err_flag_next = mis;
          mem_en_next   = ~mis;
          mem_we_next   = ~mis & we_v[sel];
          if (!mis) begin
            mem_addr_next  = addr_v[sel];
            mem_wdata_next = wdata_v[sel];
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ack_next[gnt_reg]     = 1'b1;
        err_out_next[gnt_reg] = err_flag_reg;
        state_next            = DONE;
      end
      DONE: begin
        last_next  = gnt_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      gnt_reg       <= 1'b0;
      last_reg      <= 1'b1;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_flag_reg  <= 1'b0;
      ack_reg       <= 2'b00;
      err_out_reg   <= 2'b00;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      last_reg      <= last_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      err_flag_reg  <= err_flag_next;
      ack_reg       <= ack_next;
      err_out_reg   <= err_out_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Read data passes straight through during the ack cycle, then the hold register takes over.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rd_live[gi] = ack_reg[gi] & ~we_reg & ~err_flag_reg;
      assign rdata_v[gi] = rd_live[gi] ? mem_rdata : rdata_hold_reg[gi];
      always_ff @(posedge clock) begin
        if (reset)
          rdata_hold_reg[gi] <= '0;
        else if (rd_live[gi])
          rdata_hold_reg[gi] <= mem_rdata;
      end
    end
  endgenerate

  assign ack0      = ack_reg[0];
  assign ack1      = ack_reg[1];
  assign err0      = err_out_reg[0];
  assign err1      = err_out_reg[1];
  assign rdata0    = rdata_v[0];
  assign rdata1    = rdata_v[1];
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != IDLE);
  assign gnt_id    = gnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, contention/reset sequences, and a
// randomized run scored against a word-array memory model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        ack0, ack1, err0, err1, mem_en, mem_we, busy, gnt_id;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        ack0_f, ack1_f, err0_f, err1_f, mem_en_f, mem_we_f, busy_f, gnt_id_f;
  logic [31:0] rdata0_f, rdata1_f, mem_addr_f, mem_wdata_f;
  logic [31:0] mem_rdata_f = '0;

  logic [31:0] mem_a [256] = '{default: '0};
  logic [31:0] mem_b [256] = '{default: '0};

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRI(0)) u_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRI(1)) u_fx (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_f), .ack1(ack1_f), .err0(err0_f), .err1(err1_f),
    .rdata0(rdata0_f), .rdata1(rdata1_f),
    .mem_en(mem_en_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f),
    .mem_rdata(mem_rdata_f), .busy(busy_f), .gnt_id(gnt_id_f)
  );

  // Synchronous memories: read data appears the cycle after the strobe.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem_a[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem_a[mem_addr[9:2]];
    end
    if (mem_en_f) begin
      if (mem_we_f) mem_b[mem_addr_f[9:2]] <= mem_wdata_f;
      else          mem_rdata_f <= mem_b[mem_addr_f[9:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  // One isolated access on the round-robin instance; entered and left in IDLE.
  task automatic do_access(input vec_t v);
    logic a_p, a_o, e_p;
    logic [31:0] r_p;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    tick();
    chk("issue_en", mem_en, !v.exp_err);
    chk("issue_we", mem_we, v.we && !v.exp_err);
    if (!v.exp_err) begin
      chk("issue_addr", mem_addr, v.addr);
      if (v.we) chk("issue_wdata", mem_wdata, v.wdata);
    end
    chk("issue_gnt", gnt_id, v.port);
    chk("issue_busy", busy, 1'b1);
    tick();
    a_p = v.port ? ack1 : ack0;
    a_o = v.port ? ack0 : ack1;
    e_p = v.port ? err1 : err0;
    r_p = v.port ? rdata1 : rdata0;
    chk("done_ack", a_p, 1'b1);
    chk("done_other_ack", a_o, 1'b0);
    chk("done_err", e_p, v.exp_err);
    chk("done_rdata", r_p, v.exp_rdata);
    chk("done_mem_en", mem_en, 1'b0);
    $display("txn port=%0d we=%0d addr=%h err=%0d rdata=%h", v.port, v.we, v.addr, e_p, r_p);
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("after_ack", v.port ? ack1 : ack0, 1'b0);
    chk("after_hold", v.port ? rdata1 : rdata0, v.exp_rdata);
    chk("after_busy", busy, 1'b0);
  endtask

  task automatic reset_test;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack", {ack1, ack0, ack1_f, ack0_f}, 0);
      chk("rst_err", {err1, err0, err1_f, err0_f}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_mem", {mem_en, mem_we, mem_en_f, mem_we_f}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy_gnt", {busy, gnt_id, busy_f, gnt_id_f}, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_mem_en", {mem_en, mem_en_f}, 0);
      chk("idle_busy", {busy, busy_f}, 0);
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Both ports held: round robin serves 0,1,0,1 with an ack every third cycle.
  task automatic rr_contention;
    bit ea0, ea1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      ea0 = (i % 3 == 2) && (((i - 2) / 3) % 2 == 0);
      ea1 = (i % 3 == 2) && (((i - 2) / 3) % 2 == 1);
      chk("rr_ack0", ack0, ea0);
      chk("rr_ack1", ack1, ea1);
      if (ea0) chk("rr_rdata0", rdata0, 32'hDEADBEEF);
      if (ea1) chk("rr_rdata1", rdata1, 32'h12345678);
      if (ea0 || ea1) $display("txn rr cycle=%0d port=%0d", i, ea1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  // Abort a port 0 write in ISSUE; afterwards port 0 must win the tie again.
  task automatic reset_mid_access;
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    tick();
    chk("mid_issue_en", mem_en, 1'b1);
    reset = 1'b1;
    tick();
    chk("mid_no_ack0", ack0, 1'b0);
    chk("mid_mem_en", mem_en, 1'b0);
    chk("mid_mem_we", mem_we, 1'b0);
    chk("mid_busy", busy, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    chk("mid_tie_gnt", gnt_id, 1'b0);
    tick();
    chk("mid_tie_ack0", ack0, 1'b1);
    chk("mid_tie_ack1", ack1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    chk("mid_then_ack1", ack1, 1'b1);
    chk("mid_then_rdata1", rdata1, 32'h12345678);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  // Fixed priority: port 1 starves until req0 drops, then is served at the next IDLE.
  task automatic fixed_contention;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("fx_ack0", ack0_f, (i == 2) || (i == 5) || (i == 8));
      chk("fx_ack1", ack1_f, i == 11);
      if (i == 10) chk("fx_gnt1", gnt_id_f, 1'b1);
      if (i == 8) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  // Randomized traffic on the round-robin instance against a word-array model.
  task automatic random_test;
    logic [31:0] ref_mem [256];
    logic [31:0] last_rd [2];
    logic [31:0] cur_addr [2];
    logic [31:0] cur_wdata [2];
    bit          cur_we [2];
    bit          pend [2];
    int          age [2];
    int          idx, n_txn;
    logic        a_p, e_p;
    logic [31:0] r_p, a;
    bit          w;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      last_rd[p] = '0; pend[p] = 0; age[p] = 0;
      cur_addr[p] = '0; cur_wdata[p] = '0; cur_we[p] = 0;
    end
    n_txn = 0;
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      chk("rand_dual_ack", ack0 & ack1, 1'b0);
      for (int p = 0; p < 2; p++) begin
        a_p = p[0] ? ack1 : ack0;
        e_p = p[0] ? err1 : err0;
        r_p = p[0] ? rdata1 : rdata0;
        if (a_p) begin
          chk("rand_ack_pending", pend[p], 1'b1);
          idx = int'(cur_addr[p][9:2]);
          chk("rand_err", e_p, cur_addr[p][1:0] != 2'b00);
          if (cur_addr[p][1:0] == 2'b00) begin
            if (cur_we[p]) ref_mem[idx] = cur_wdata[p];
            else           last_rd[p] = ref_mem[idx];
          end
          chk("rand_rdata", r_p, last_rd[p]);
          $display("txn rand port=%0d we=%0d addr=%h err=%0d rdata=%h", p, cur_we[p], cur_addr[p], e_p, r_p);
          n_txn++;
          pend[p] = 0;
          drive(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
        end else begin
          chk("rand_rd_hold", r_p, last_rd[p]);
          if (pend[p]) begin
            age[p]++;
            if (age[p] > 12) begin
              chk("rand_timeout_cycles", age[p], 0);
              pend[p] = 0;
              drive(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
            end
          end
        end
        if (!pend[p] && cyc < 1900 && $urandom_range(1, 0) == 1) begin
          w = $urandom_range(1, 0) == 1;
          a = 32'($urandom_range(255, 128)) << 2;
          if ($urandom_range(7, 0) == 0) a = a + 32'($urandom_range(3, 1));
          cur_addr[p] = a;
          cur_we[p] = w;
          cur_wdata[p] = $urandom;
          pend[p] = 1;
          age[p] = 0;
          drive(p[0], 1'b1, w, a, cur_wdata[p]);
        end
      end
    end
    chk("rand_drained", {30'd0, pend[1], pend[0]}, 0);
    $display("random transactions completed: %0d", n_txn);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h13, 32'h5555AAAA, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 32'h22, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678};
    vecs[8] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};

    reset_test();
    for (int i = 0; i < 9; i++) do_access(vecs[i]);
    rr_contention();
    do_access(vecs[1]);
    reset_mid_access();
    fixed_contention();
    random_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
